// File: rtl/router_pkg.sv
// Shared types and constants for the router output-channel packet FIFO.
// The header length field sits above the two flag bits of the header byte.
package router_pkg;

    localparam int LEN_LSB       = 2;
    localparam int ROUTER_DATA_W = 8;

    // Default-width stored entry; parametrised instances build the same layout locally.
    typedef struct packed {
        logic                     hdr;
        logic [ROUTER_DATA_W-1:0] data;
    } router_entry_t;

    typedef enum logic {
        RD_IDLE    = 1'b0,
        RD_PAYLOAD = 1'b1
    } rd_state_e;

endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port storage for the packet FIFO: synchronous write, registered read.
// The array itself carries no reset so it maps onto block RAM; only the read register clears.
module router_fifo_mem #(
    parameter int WIDTH  = 9,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_array [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_array[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_data <= '0;
        end else if (clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_array[rd_addr];
        end
    end

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware per-channel output FIFO: stores a header flag with every byte,
// tracks packet boundaries on the read side and flags framing errors.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int  DATA_W   = 8,
    parameter int  DEPTH    = 16,
    localparam int ADDR_W   = $clog2(DEPTH),
    parameter int  AFULL_TH = DEPTH - 2,
    parameter int  MAX_PKTS = DEPTH,
    localparam int PKT_W    = $clog2(MAX_PKTS + 1)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              ifd_state,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_enb,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              last,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic [PKT_W-1:0]  pkt_count,
    output logic              pkt_err
);

    typedef struct packed {
        logic              hdr;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic [PKT_W-1:0]  pkt_count_reg, pkt_count_next;
    logic              pkt_err_reg, pkt_err_next;
    logic              valid_reg, valid_next;
    logic              last_reg, last_next;
    rd_state_e         state_reg, state_next;
    logic [DATA_W-2:0] remaining_reg, remaining_next;

    logic              wr_acc, rd_acc;
    logic              pkt_inc, pkt_dec;
    logic              cur_hdr;
    logic [DATA_W-2:0] len_plus1, rem_eff;
    entry_t            wr_entry, rd_entry;
    logic              hdr_shadow_reg [DEPTH];

    assign empty       = (count_reg == '0);
    assign full        = (count_reg == (ADDR_W+1)'(DEPTH));
    assign almost_full = (count_reg >= (ADDR_W+1)'(AFULL_TH));

    // full/empty are judged on the pre-cycle count, so a read never frees room for a same-cycle write
    assign wr_acc = write_enb && !full  && !soft_reset;
    assign rd_acc = read_enb  && !empty && !soft_reset;

    assign wr_entry = '{hdr: ifd_state, data: data_in};

    router_fifo_mem #(
        .WIDTH  (DATA_W + 1),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock   (clock),
        .resetn  (resetn),
        .clr     (soft_reset),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_entry),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_entry)
    );

    // Header flags are also kept in flops so the tracker can classify an entry in the cycle it is read.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hdr_shadow
        always_ff @(posedge clock) begin
            if (wr_acc && (wr_ptr_reg == ADDR_W'(gi))) begin
                hdr_shadow_reg[gi] <= ifd_state;
            end
        end
    end

    assign cur_hdr = hdr_shadow_reg[rd_ptr_reg];

    // The header byte is still on data_out for the first payload read, so its length is taken from there.
    assign len_plus1 = (DATA_W-1)'(rd_entry.data[DATA_W-1:LEN_LSB]) + (DATA_W-1)'(1);
    assign rem_eff   = rd_entry.hdr ? len_plus1 : remaining_reg;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            pkt_count_reg <= '0;
            pkt_err_reg   <= 1'b0;
            valid_reg     <= 1'b0;
            last_reg      <= 1'b0;
            state_reg     <= RD_IDLE;
            remaining_reg <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            pkt_count_reg <= pkt_count_next;
            pkt_err_reg   <= pkt_err_next;
            valid_reg     <= valid_next;
            last_reg      <= last_next;
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
        end
    end

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        pkt_count_next = pkt_count_reg;
        pkt_err_next   = pkt_err_reg;
        valid_next     = 1'b0;
        last_next      = 1'b0;
        state_next     = state_reg;
        remaining_next = remaining_reg;
        pkt_inc        = wr_acc && ifd_state;
        pkt_dec        = 1'b0;

        if (wr_acc) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        if (rd_acc) begin
            valid_next = 1'b1;
            unique case (state_reg)
                RD_IDLE: begin
                    if (cur_hdr) begin
                        state_next = RD_PAYLOAD;
                    end else begin
                        pkt_err_next = 1'b1;
                    end
                end
                RD_PAYLOAD: begin
                    if (cur_hdr) begin
                        // Header inside a packet: drop the open packet and start over on this one.
                        pkt_err_next = 1'b1;
                        pkt_dec      = 1'b1;
                    end else if (rem_eff == (DATA_W-1)'(1)) begin
                        last_next  = 1'b1;
                        pkt_dec    = 1'b1;
                        state_next = RD_IDLE;
                    end else begin
                        remaining_next = rem_eff - 1'b1;
                    end
                end
                default: state_next = RD_IDLE;
            endcase
        end

        if (pkt_inc && !pkt_dec) begin
            if (pkt_count_reg == PKT_W'(MAX_PKTS)) begin
                pkt_err_next = 1'b1;
            end else begin
                pkt_count_next = pkt_count_reg + 1'b1;
            end
        end else if (pkt_dec && !pkt_inc && (pkt_count_reg != '0)) begin
            pkt_count_next = pkt_count_reg - 1'b1;
        end

        if (soft_reset) begin
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            pkt_count_next = '0;
            pkt_err_next   = 1'b0;
            valid_next     = 1'b0;
            last_next      = 1'b0;
            state_next     = RD_IDLE;
            remaining_next = '0;
        end
    end

    assign data_out   = rd_entry.data;
    assign data_valid = valid_reg;
    assign last       = last_reg;
    assign count      = count_reg;
    assign pkt_count  = pkt_count_reg;
    assign pkt_err    = pkt_err_reg;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed self-checking bench for router_pkt_fifo: inputs change on the falling edge,
// outputs are compared on the following falling edge.
module tb_router_pkt_fifo;

    logic       clock      = 1'b0;
    logic       resetn     = 1'b0;
    logic       soft_reset = 1'b0;
    logic       write_enb  = 1'b0;
    logic       ifd_state  = 1'b0;
    logic [7:0] data_in    = 8'h00;
    logic       read_enb   = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, last, empty, full, almost_full, pkt_err;
    logic [4:0] count;
    logic [4:0] pkt_count;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    router_pkt_fifo #(
        .DATA_W   (8),
        .DEPTH    (16),
        .AFULL_TH (14),
        .MAX_PKTS (16)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .soft_reset  (soft_reset),
        .write_enb   (write_enb),
        .ifd_state   (ifd_state),
        .data_in     (data_in),
        .read_enb    (read_enb),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .last        (last),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .pkt_count   (pkt_count),
        .pkt_err     (pkt_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the next falling edge.
    task automatic step(input logic we, input logic h, input logic [7:0] d, input logic re);
        write_enb = we;
        ifd_state = h;
        data_in   = d;
        read_enb  = re;
        @(negedge clock);
    endtask

    task automatic wr(input logic h, input logic [7:0] d);
        step(1'b1, h, d, 1'b0);
        $display("wr hdr=%0b data=0x%02h count=%0d pkt_count=%0d", h, d, count, pkt_count);
    endtask

    task automatic rd(input string tag, input logic [7:0] exp_d, input logic exp_l);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        $display("rd %s data_out=0x%02h valid=%0b last=%0b", tag, data_out, data_valid, last);
        chk({tag, "_data"}, data_out, exp_d);
        chk({tag, "_valid"}, data_valid, 1'b1);
        chk({tag, "_last"}, last, exp_l);
    endtask

    initial begin
        logic [7:0] d;

        // 1: reset values, then a 3-byte packet written and read back
        #12;
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_afull", almost_full, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_err", pkt_err, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        wr(1'b1, 8'h0C);
        wr(1'b0, 8'h11);
        wr(1'b0, 8'h22);
        wr(1'b0, 8'h33);
        wr(1'b0, 8'h5A);
        chk("t1_count", count, 5);
        chk("t1_pkt_count", pkt_count, 1);
        rd("t1_r0", 8'h0C, 1'b0);
        rd("t1_r1", 8'h11, 1'b0);
        rd("t1_r2", 8'h22, 1'b0);
        rd("t1_r3", 8'h33, 1'b0);
        rd("t1_r4", 8'h5A, 1'b1);
        chk("t1_pkt_after", pkt_count, 0);
        chk("t1_empty", empty, 1'b1);
        chk("t1_err", pkt_err, 1'b0);

        // 2: fill to DEPTH with one 14-byte packet, overflow attempt, drain across wrap
        for (int i = 0; i < 16; i++) begin
            d = (i == 0) ? 8'h38 : (i == 15) ? 8'hC3 : 8'(8'h40 + i);
            wr(i == 0, d);
            if (i == 12) chk("t2_afull_13", almost_full, 1'b0);
            if (i == 13) chk("t2_afull_14", almost_full, 1'b1);
            if (i == 14) chk("t2_full_15", full, 1'b0);
        end
        chk("t2_full", full, 1'b1);
        chk("t2_count16", count, 16);
        wr(1'b1, 8'hFF);
        chk("t2_ovf_count", count, 16);
        chk("t2_ovf_pkt", pkt_count, 1);
        for (int i = 0; i < 16; i++) begin
            d = (i == 0) ? 8'h38 : (i == 15) ? 8'hC3 : 8'(8'h40 + i);
            rd($sformatf("t2_r%0d", i), d, i == 15);
        end
        chk("t2_empty", empty, 1'b1);
        chk("t2_pkt", pkt_count, 0);
        chk("t2_err", pkt_err, 1'b0);

        // 3: simultaneous read/write at count 8, then at empty (also 4: length-0 header)
        wr(1'b1, 8'h18);
        for (int i = 1; i <= 6; i++) wr(1'b0, 8'(8'h60 + i));
        wr(1'b0, 8'h6F);
        chk("t3_count8", count, 8);
        step(1'b1, 1'b1, 8'h04, 1'b1);
        chk("t3_s0_data", data_out, 8'h18);
        chk("t3_s0_count", count, 8);
        step(1'b1, 1'b0, 8'h77, 1'b1);
        chk("t3_s1_data", data_out, 8'h61);
        chk("t3_s1_count", count, 8);
        step(1'b1, 1'b0, 8'h99, 1'b1);
        chk("t3_s2_data", data_out, 8'h62);
        chk("t3_s2_count", count, 8);
        step(1'b1, 1'b1, 8'h00, 1'b1);
        chk("t3_s3_data", data_out, 8'h63);
        chk("t3_s3_count", count, 8);
        chk("t3_s3_last", last, 1'b0);
        chk("t3_pkt3", pkt_count, 3);
        rd("t3_r4", 8'h64, 1'b0);
        rd("t3_r5", 8'h65, 1'b0);
        rd("t3_r6", 8'h66, 1'b0);
        rd("t3_rp", 8'h6F, 1'b1);
        rd("t3_h2", 8'h04, 1'b0);
        rd("t3_p2", 8'h77, 1'b0);
        rd("t3_q2", 8'h99, 1'b1);
        rd("t4_h0", 8'h00, 1'b0);
        chk("t3_empty", empty, 1'b1);
        chk("t4_pkt1", pkt_count, 1);
        step(1'b1, 1'b0, 8'hA5, 1'b1);
        chk("t3_e_valid", data_valid, 1'b0);
        chk("t3_e_count", count, 1);
        chk("t3_e_hold", data_out, 8'h00);
        rd("t4_par", 8'hA5, 1'b1);
        chk("t4_pkt0", pkt_count, 0);
        chk("t4_err", pkt_err, 1'b0);

        // 5: header arrives before the parity byte of the open packet
        wr(1'b1, 8'h08);
        wr(1'b0, 8'h31);
        wr(1'b1, 8'h0C);
        wr(1'b0, 8'h41);
        wr(1'b0, 8'h42);
        wr(1'b0, 8'h43);
        wr(1'b0, 8'h4F);
        chk("t5_pkt2", pkt_count, 2);
        rd("t5_h1", 8'h08, 1'b0);
        rd("t5_p1", 8'h31, 1'b0);
        chk("t5_err_before", pkt_err, 1'b0);
        rd("t5_h2", 8'h0C, 1'b0);
        chk("t5_err", pkt_err, 1'b1);
        chk("t5_pkt_abandon", pkt_count, 1);
        rd("t5_a", 8'h41, 1'b0);
        rd("t5_b", 8'h42, 1'b0);
        rd("t5_c", 8'h43, 1'b0);
        rd("t5_par", 8'h4F, 1'b1);
        chk("t5_pkt0", pkt_count, 0);
        chk("t5_err_sticky", pkt_err, 1'b1);
        wr(1'b1, 8'h10);
        chk("t5_pre_count", count, 1);
        soft_reset = 1'b1;
        step(1'b1, 1'b1, 8'h20, 1'b1);
        soft_reset = 1'b0;
        $display("soft_reset count=%0d pkt_count=%0d err=%0b data_out=0x%02h", count, pkt_count, pkt_err, data_out);
        chk("t5_sr_err", pkt_err, 1'b0);
        chk("t5_sr_count", count, 0);
        chk("t5_sr_pkt", pkt_count, 0);
        chk("t5_sr_data", data_out, 8'h00);
        chk("t5_sr_empty", empty, 1'b1);

        // 6: asynchronous reset between clock edges mid-packet
        wr(1'b1, 8'h08);
        wr(1'b0, 8'h51);
        rd("t6_h", 8'h08, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        #2 resetn = 1'b0;
        #1;
        $display("async reset count=%0d data_out=0x%02h", count, data_out);
        chk("t6_ar_count", count, 0);
        chk("t6_ar_data", data_out, 8'h00);
        chk("t6_ar_pkt", pkt_count, 0);
        chk("t6_ar_empty", empty, 1'b1);
        @(negedge clock);
        resetn = 1'b1;
        wr(1'b1, 8'h04);
        wr(1'b0, 8'hB1);
        wr(1'b0, 8'hB2);
        rd("t6_r0", 8'h04, 1'b0);
        rd("t6_r1", 8'hB1, 1'b0);
        rd("t6_r2", 8'hB2, 1'b1);
        chk("t6_err", pkt_err, 1'b0);
        chk("t6_pkt", pkt_count, 0);
        chk("t6_empty", empty, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
Packet-aware FIFO, next generation of the router's per-channel output buffer.
- Parametrised in data width, depth and almost-full threshold.
- Stores a header-flag sidebit with every byte and tracks packet boundaries on the read side.
- Reports completed-packet occupancy, and flags header/length framing errors.
- One instance per router output channel, between the register/synchroniser stage and the destination port.

Parameters:
DATA_W, 8, payload width; header length field = data_in[DATA_W-1:2]
DEPTH, 16, entries; power of two, >= 4
ADDR_W, $clog2(DEPTH), pointer width (derived, not overridden)
AFULL_TH, DEPTH-2, occupancy at or above which almost_full asserts
MAX_PKTS, DEPTH, capacity of the packet counter

Ports:
clock  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
soft_reset  in  1  synchronous active-high flush (timeout from FSM)
write_enb  in  1  write request
ifd_state  in  1  high when data_in is a header byte
data_in  in  DATA_W  byte to store
read_enb  in  1  read request
data_out  out  DATA_W  registered read data
data_valid  out  1  data_out updated this cycle
last  out  1  data_out is parity byte (end of packet)
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_full  out  1  count >= AFULL_TH
count  out  ADDR_W+1  occupancy in entries
pkt_count  out  $clog2(MAX_PKTS+1)  headers written minus packets fully read
pkt_err  out  1  sticky framing error

Behaviour:
- All state on the rising edge of clock.
- resetn low (async): pointers, count, pkt_count = 0; empty = 1; full = almost_full = 0; data_out = 0; data_valid = last = pkt_err = 0; read tracker idle.
- soft_reset (resetn high): same values as reset, applied synchronously. Overrides any write/read in that cycle.
- Write accepted = write_enb && !full. Stores {ifd_state, data_in} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Read accepted = read_enb && !empty. data_out = mem[rd_ptr] data bits, one cycle latency; data_valid pulses with it.
- Rejected requests are silently dropped: no pointer, count or flag change, data_out holds.
- Simultaneous accepted read and write: count unchanged, both pointers advance. At full with read_enb, the write is still rejected (full is evaluated before the read). At empty, a simultaneous write is accepted and the read is rejected.
- empty, full, almost_full decode combinationally from the count register, so they change in the same cycle as count.
- Read tracker states:
  - IDLE: accepted read of a header entry loads remaining = length + 1 and moves to PAYLOAD. A non-header entry is still output, sets pkt_err, and stays in IDLE.
  - PAYLOAD: each accepted read decrements remaining. The read with remaining == 1 asserts last with data_out, decrements pkt_count and returns to IDLE.
  - A header read while in PAYLOAD sets pkt_err, abandons the current packet (pkt_count -1) and reloads for the new header.
- Length 0 header: remaining = 1, so the next byte is the parity byte, with last.
- pkt_count:
  - +1 on an accepted header write; -1 on a packet completion or abandon; both in the same cycle leave it unchanged.
  - Saturates at MAX_PKTS; saturation sets pkt_err.
- Width rules:
  - remaining is DATA_W-1 bits wide, enough for length + 1.
  - count is ADDR_W+1 bits, so full is distinguishable from empty.
- pkt_err clears only on resetn or soft_reset.
- resetn asserted mid-packet: everything discarded; the tracker restarts in IDLE.

Decomposition:
- Package router_pkg:
  - localparam for the header length field position (LEN_LSB = 2)
  - typedef for the stored entry, struct {logic hdr; logic [DATA_W-1:0] data}
  - enum rd_state_e {RD_IDLE, RD_PAYLOAD}
- Sub-module router_fifo_mem: simple dual-port storage. Synchronous write, registered read, no reset on the array.
- Pointer, count and tracker logic stay in router_pkt_fifo.

Test Plan:
1. Reset, then write header 0x0C (length 3) with ifd_state = 1, plus bytes 0x11, 0x22, 0x33 and parity 0x5A. Expect count = 5, pkt_count = 1. Read 5 times: data_out sequence 0x0C, 0x11, 0x22, 0x33, 0x5A; last only with 0x5A; afterwards pkt_count = 0, empty = 1.
2. Write DEPTH entries: full = 1, almost_full rises at count 14. Write again: count stays 16, no overwrite. Read all and check order across the wrap-around.
3. At count = 8, assert write_enb and read_enb together for 4 cycles: count stays 8, data order preserved. Repeat at count = 0: write accepted, read ignored, data_valid = 0.
4. Header length 0 followed by parity 0xA5: reading gives last on the second byte; pkt_count goes 1 -> 0.
5. Header, 1 payload byte, then a second header before parity, all read out: pkt_err = 1 at the second header read, tracker reloads. soft_reset then clears pkt_err, count, pkt_count and data_out to 0.
6. Assert resetn low asynchronously mid-packet, between clock edges: outputs go to reset values immediately. After release, a fresh packet is read correctly.
